// File: rtl/alu_sequencer_pkg.sv
// Shared opcode and state definitions for the ALU bus sequencer.
// This package also provides a sizing helper for the settle counter.
package alu_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_LDN     = 2'b00,
    OP_SUB     = 2'b01,
    OP_CMP     = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SETTLE = 2'b01,
    S_DONE   = 2'b10
  } state_e;

  // The counter must hold values up to cycles-1, and it is never narrower than one bit.
  function automatic int unsigned counter_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/alu_sequencer_settle_timer.sv
// Down-counter that measures how long the ALU inputs have been held stable.
// A load restarts the count, and the zero flag marks the final settle cycle.
module alu_sequencer_settle_timer #(
  parameter int unsigned CYCLES = 4,
  parameter int unsigned WIDTH  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic zero
);

  localparam logic [WIDTH-1:0] LOAD_VALUE = WIDTH'(CYCLES - 1);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VALUE;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Bus-side initiator for the tri-state ALU. It takes one LDN/SUB/CMP request at a time,
// holds the ALU inputs for a fixed settle time, and owns the accumulator.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_operand,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_sub,
  output logic        alu_oe_n,
  input  logic [31:0] alu_result,
  output logic [31:0] acc,
  output logic        done,
  output logic        skip,
  output logic        error
);

  localparam int unsigned COUNT_WIDTH = counter_width(SETTLE_CYCLES);

  state_e state;
  logic   accept;
  logic   timer_zero;

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid && req_ready;

  alu_sequencer_settle_timer #(
    .CYCLES (SETTLE_CYCLES),
    .WIDTH  (COUNT_WIDTH)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (accept && !req_op[1]),
    .enable (state == S_SETTLE),
    .zero   (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      acc      <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sub  <= 1'b0;
      alu_oe_n <= 1'b1;
      done     <= 1'b0;
      skip     <= 1'b0;
      error    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (op_e'(req_op))
              OP_LDN: begin
                alu_a    <= '0;
                alu_b    <= req_operand;
                alu_sub  <= 1'b1;
                alu_oe_n <= 1'b0;
                state    <= S_SETTLE;
              end
              OP_SUB: begin
                alu_a    <= acc;
                alu_b    <= req_operand;
                alu_sub  <= 1'b1;
                alu_oe_n <= 1'b0;
                state    <= S_SETTLE;
              end
              OP_CMP: begin
                done  <= 1'b1;
                skip  <= acc[31];
                state <= S_DONE;
              end
              default: begin
                done  <= 1'b1;
                error <= 1'b1;
                state <= S_DONE;
              end
            endcase
          end
        end
        // The ripple result is only trusted once the timer has run out.
        S_SETTLE: begin
          if (timer_zero) begin
            acc      <= alu_result;
            alu_oe_n <= 1'b1;
            done     <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          skip  <= 1'b0;
          error <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ripple ALU.
// Expected results come from plain two's-complement arithmetic on a model accumulator.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  localparam int unsigned SETTLE = 4;
  localparam logic [31:0] BUS_IDLE = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_operand;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_sub;
  logic        alu_oe_n;
  logic [31:0] alu_result;
  logic [31:0] acc;
  logic        done;
  logic        skip;
  logic        error;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_acc;
  int          ripple_count;

  always #5 clk = ~clk;

  alu_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_operand (req_operand),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sub     (alu_sub),
    .alu_oe_n    (alu_oe_n),
    .alu_result  (alu_result),
    .acc         (acc),
    .done        (done),
    .skip        (skip),
    .error       (error)
  );

  // The ALU result is valid only after SETTLE-1 full cycles of enabled drive.
  // A released or unsettled bus shows a marker value, so an early or late capture is visible.
  always @(posedge clk) begin
    if (alu_oe_n) ripple_count <= 0;
    else if (ripple_count < 15) ripple_count <= ripple_count + 1;
  end

  assign alu_result = (alu_oe_n || ripple_count < int'(SETTLE) - 1) ? BUS_IDLE
                    : (alu_sub ? alu_a - alu_b : alu_a + alu_b);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Run one full transaction and check latency, bus usage, flags and the accumulator.
  task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] operand, input string tag);
    int          wait_cycles;
    int          cycles;
    int          oe_low;
    int          stray_flags;
    logic        arith;
    logic        exp_skip;
    logic        exp_error;
    logic [31:0] exp_acc;

    wait_cycles = 0;
    while (!req_ready && wait_cycles < 20) begin
      step();
      wait_cycles++;
    end
    check_output({tag, "_ready"}, 32'(req_ready), 32'd1);

    arith     = (op == OP_LDN) || (op == OP_SUB);
    exp_skip  = (op == OP_CMP) && model_acc[31];
    exp_error = (op == OP_ILLEGAL);
    case (op)
      OP_LDN:  exp_acc = 32'd0 - operand;
      OP_SUB:  exp_acc = model_acc - operand;
      default: exp_acc = model_acc;
    endcase

    req_valid   = 1'b1;
    req_op      = op;
    req_operand = operand;
    step();
    req_valid   = 1'b0;
    req_op      = 2'($urandom);
    req_operand = $urandom;

    cycles      = 0;
    oe_low      = 0;
    stray_flags = 0;
    while (!done && cycles < 50) begin
      if (!alu_oe_n) oe_low++;
      if (skip || error) stray_flags++;
      step();
      cycles++;
    end

    check_output({tag, "_latency"}, 32'(cycles), arith ? 32'(SETTLE) : 32'd0);
    check_output({tag, "_oe_low_cycles"}, 32'(oe_low), arith ? 32'(SETTLE) : 32'd0);
    check_output({tag, "_stray_flags"}, 32'(stray_flags), 32'd0);
    check_output({tag, "_acc"}, acc, exp_acc);
    check_output({tag, "_skip"}, 32'(skip), 32'(exp_skip));
    check_output({tag, "_error"}, 32'(error), 32'(exp_error));
    check_output({tag, "_oe_released"}, 32'(alu_oe_n), 32'd1);
    check_output({tag, "_ready_low"}, 32'(req_ready), 32'd0);
    step();
    check_output({tag, "_done_clear"}, {29'd0, done, skip, error}, 32'd0);
    check_output({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    model_acc = exp_acc;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] simulation did not terminate");
  end

  initial begin
    int          cycles;
    int          stray;
    logic [1:0]  op;
    logic [31:0] operand;

    reset       = 1'b1;
    req_valid   = 1'b0;
    req_op      = 2'b00;
    req_operand = 32'd0;
    model_acc   = 32'd0;
    step();
    step();
    check_output("reset_acc", acc, 32'd0);
    check_output("reset_alu_a", alu_a, 32'd0);
    check_output("reset_alu_b", alu_b, 32'd0);
    check_output("reset_ctrl", {28'd0, alu_sub, alu_oe_n, done, skip}, 32'h4);
    check_output("reset_error", 32'(error), 32'd0);
    reset = 1'b0;
    step();
    check_output("reset_ready", 32'(req_ready), 32'd1);

    apply_stimulus(OP_LDN, 32'h0000_0005, "ldn5");
    check_output("ldn5_value", acc, 32'hFFFF_FFFB);
    apply_stimulus(OP_SUB, 32'h0000_0005, "sub5");
    check_output("sub5_value", acc, 32'hFFFF_FFF6);
    apply_stimulus(OP_CMP, 32'h1234_5678, "cmp_neg");
    apply_stimulus(OP_LDN, 32'hFFFF_FFF6, "ldn_neg");
    check_output("ldn_neg_value", acc, 32'h0000_000A);
    apply_stimulus(OP_CMP, 32'd0, "cmp_pos");
    apply_stimulus(OP_SUB, 32'h0000_000A, "sub_zero");
    check_output("sub_zero_value", acc, 32'd0);

    // An illegal op followed by a CMP held on req_valid must accept two cycles later.
    apply_stimulus(OP_LDN, 32'h0000_0003, "ldn3");
    req_valid = 1'b1;
    req_op    = OP_ILLEGAL;
    step();
    req_op = OP_CMP;
    check_output("ill_done", {30'd0, done, error}, 32'h3);
    check_output("ill_ready_low", 32'(req_ready), 32'd0);
    check_output("ill_acc", acc, model_acc);
    step();
    check_output("ill_gap_done", 32'(done), 32'd0);
    check_output("ill_gap_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    check_output("held_cmp_done", {29'd0, done, skip, error}, {29'd0, 1'b1, model_acc[31], 1'b0});
    step();
    check_output("held_cmp_clear", 32'(done), 32'd0);

    // A reset during the settle aborts the SUB without a completion pulse.
    apply_stimulus(OP_SUB, 32'h0000_0001, "sub_pre_reset");
    req_valid   = 1'b1;
    req_op      = OP_SUB;
    req_operand = 32'h0000_0007;
    step();
    req_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset     = 1'b0;
    model_acc = 32'd0;
    check_output("abort_acc", acc, 32'd0);
    check_output("abort_oe", 32'(alu_oe_n), 32'd1);
    check_output("abort_bus", alu_result, BUS_IDLE);
    stray = 0;
    for (cycles = 0; cycles < 8; cycles++) begin
      if (done) stray++;
      step();
    end
    check_output("abort_no_done", 32'(stray), 32'd0);

    apply_stimulus(OP_LDN, 32'h8000_0000, "ldn_min");
    check_output("ldn_min_value", acc, 32'h8000_0000);
    apply_stimulus(OP_LDN, 32'd0, "ldn_zero");
    apply_stimulus(OP_SUB, 32'h0000_0001, "sub_wrap");
    check_output("sub_wrap_value", acc, 32'hFFFF_FFFF);

    for (int i = 0; i < 24; i++) begin
      op      = 2'($urandom_range(0, 3));
      operand = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      apply_stimulus(op, operand, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Bus-side initiator for the 32-bit tri-state ALU: accepts one arithmetic request at a time, drives the ALU operand, SUB and OE_n lines, and waits a fixed settle time for the ALU's ripple propagation. It then captures RESULT into the accumulator and releases the bus. It sits between the Baby control unit, which issues LDN/SUB/CMP, and the ALU, and owns the architectural accumulator.

## Interface
- SETTLE_CYCLES, 4, clock cycles the ALU inputs are held before RESULT is sampled; legal range 1..255.
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  block can accept a request; high only in IDLE.
- REQ_OP  in  2  00 = LDN, 01 = SUB, 10 = CMP, 11 = illegal.
- REQ_OPERAND  in  32  store word for LDN/SUB; ignored for CMP and illegal.
- ALU_A  out  32  ALU A operand.
- ALU_B  out  32  ALU B operand.
- ALU_SUB  out  1  ALU subtract select.
- ALU_OE_n  out  1  ALU output enable, active low.
- ALU_RESULT  in  32  ALU result bus; may be z when ALU_OE_n = 1.
- ACC  out  32  accumulator.
- DONE  out  1  one-cycle completion pulse.
- SKIP  out  1  pulses with DONE when a CMP finds ACC[31] = 1.
- ERROR  out  1  pulses with DONE for an illegal op.

## Operation
- States: IDLE, SETTLE, DONE.
- Handshake:
  - A transfer occurs on a rising edge with REQ_VALID & REQ_READY.
  - REQ_OP and REQ_OPERAND are sampled only on that edge.
- LDN accept:
  - ALU_A <= 0, ALU_B <= operand, ALU_SUB <= 1, ALU_OE_n <= 0.
  - Counter <= SETTLE_CYCLES-1; go to SETTLE.
- SUB accept:
  - ALU_A <= ACC, ALU_B <= operand, ALU_SUB <= 1, ALU_OE_n <= 0.
  - Go to SETTLE.
- SETTLE:
  - Counter nonzero: decrement.
  - Counter zero: ACC <= ALU_RESULT, ALU_OE_n <= 1, DONE <= 1; go to DONE.
- CMP accept:
  - No bus activity; ALU_OE_n stays 1.
  - Go to DONE with DONE = 1 and SKIP = ACC[31].
- Illegal accept:
  - Go to DONE with DONE = 1 and ERROR = 1; ACC unchanged.
- DONE: clear DONE, SKIP and ERROR; return to IDLE.
- Arithmetic is modulo 2^32, with no carry or overflow output.
  - LDN of 0x80000000 yields 0x80000000.
  - LDN of 0 yields 0.
- ALU_A, ALU_B and ALU_SUB hold their last values in IDLE; only ALU_OE_n gates the bus.
- The block never drives ALU_OE_n low outside SETTLE.

## Timing
- Reset values:
  - Registers: state IDLE, ACC = 0, ALU_A = 0, ALU_B = 0, ALU_SUB = 0, ALU_OE_n = 1.
  - Pulses: DONE = 0, SKIP = 0, ERROR = 0.
  - REQ_READY is 1 in the cycle after reset deasserts.
- LDN/SUB, with the accept edge as edge 0:
  - ALU driven from edge 0.
  - ACC updated and bus released at edge SETTLE_CYCLES.
  - DONE high between edges SETTLE_CYCLES and SETTLE_CYCLES+1.
  - REQ_READY high again after edge SETTLE_CYCLES+1.
  - Back-to-back period is SETTLE_CYCLES+2 cycles.
- CMP/illegal: DONE high in the cycle after the accept edge; period is 2 cycles.
- SKIP and ERROR are never high without DONE.
- REQ_VALID while not ready is ignored; the requester holds the request until it is accepted.
- RESET during SETTLE or DONE:
  - Abort the operation, release the bus (ALU_OE_n = 1) and clear ACC.
  - No DONE pulse for the aborted request.
- RESET has priority over a simultaneous accept.

## Structure
- Shared header Components/alu_ops.vh holds OP_LDN, OP_SUB, OP_CMP, OP_ILLEGAL, and the state encodings S_IDLE, S_SETTLE, S_DONE.
- One sub-module, settle_timer:
  - Parameterised down-counter with load and a zero flag.
  - Counter width is $clog2(SETTLE_CYCLES+1), minimum 1.

## Test plan
Bench instantiates alu_sequencer together with the real alu, with SETTLE_CYCLES = 4.
- Reset, then LDN 0x00000005 -> ACC = 0xFFFFFFFB; DONE high exactly at cycle 5 after accept; ALU_OE_n low for exactly 4 cycles; SKIP = 0.
- With ACC = 0xFFFFFFFB, SUB 0x00000005 -> ACC = 0xFFFFFFF6; then CMP -> DONE with SKIP = 1 one cycle after accept; ALU_OE_n never low during the CMP.
- LDN 0xFFFFFFF6 -> ACC = 0x0000000A; CMP -> SKIP = 0. Then SUB 0x0000000A -> ACC = 0.
- Illegal op 11 -> DONE with ERROR = 1 and ACC unchanged. REQ_VALID held continuously -> next accept occurs exactly 2 cycles later and REQ_READY is low in between.
- Assert RESET at cycle 2 of a SUB settle:
  - Next cycle ACC = 0 and ALU_OE_n = 1.
  - No DONE pulse.
  - ALU_RESULT reads z.
- Wrap: LDN 0x80000000 -> 0x80000000; ACC = 0 then SUB 0x00000001 -> 0xFFFFFFFF.
